vend_coin_sequencer: RTL and testbench

- Front-end controller for the vending-machine FSM (`fsm`).
- Captures raw coin-sensor pulses, which may arrive simultaneously, and holds them as per-denomination pending counts.
- Feeds the FSM one coin pulse at a time, spaced by a guard gap.
- On a dispense (`d`), pays out the reported change (`r`) one unit coin at a time through a req/ack hopper handshake.

---
 rtl/vend_pkg.sv | 9 +
 rtl/coin_pend_counter.sv | 26 ++
 rtl/vend_coin_sequencer.sv | 130 +++++++++++++
 tb/tb_vend_coin_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding, denomination indices and widths for the coin sequencer.
package vend_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, GAP_WAIT, CHANGE} state_e;
    localparam int DEN_ONE  = 0;
    localparam int DEN_TWO  = 1;
    localparam int DEN_FIVE = 2;
    localparam int NDEN     = 3;
    localparam int CHG_W    = 3;
endpackage

// File: rtl/coin_pend_counter.sv
// coin_pend_counter: saturating pending-coin counter; drop flags a capture lost to saturation.
module coin_pend_counter #(
    parameter int W = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic nz,
    output logic drop
);
    logic [W-1:0] cnt_q, cnt_d;
    logic full;
    // simultaneous capture and issue cancel, so a full counter still accepts the coin
    always_comb begin
        full  = &cnt_q;
        nz    = |cnt_q;
        drop  = inc & ~dec & full;
        cnt_d = (inc & ~dec & ~full) ? cnt_q + W'(1) :
                (dec & ~inc & nz)    ? cnt_q - W'(1) : cnt_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/vend_coin_sequencer.sv
// vend_coin_sequencer: buffers coin sensor pulses, feeds them to the vending FSM one at a time,
// and pays out dispense change through a req/ack hopper with a timeout fault.
module vend_coin_sequencer
    import vend_pkg::*;
#(
    parameter int GAP         = 2,
    parameter int CNT_W       = 2,
    parameter int HOP_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             coin_one,
    input  logic             coin_two,
    input  logic             coin_five,
    output logic             one,
    output logic             two,
    output logic             five,
    input  logic             d,
    input  logic [CHG_W-1:0] r,
    output logic             hop_req,
    input  logic             hop_ack,
    output logic             coin_reject,
    output logic             busy,
    output logic             hop_fault
);
    localparam int GW = $clog2(GAP + 1);
    localparam int TW = $clog2(HOP_TIMEOUT + 1);

    logic [NDEN-1:0] coin_in, nz, drop, sel, dec;
    state_e state_q, state_d;
    logic [NDEN-1:0] coin_q, coin_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [CHG_W-1:0] chg_q, chg_d;
    logic [TW-1:0] to_q, to_d;
    logic hop_req_q, hop_req_d, fault_q, fault_d, rej_q, rej_d;

    assign coin_in = {coin_five, coin_two, coin_one};
    // lowest set bit wins: one before two before five
    assign sel = nz & (~nz + NDEN'(1));
    assign dec = (state_q == IDLE) ? sel : '0;

    for (genvar i = 0; i < NDEN; i++) begin : g_cnt
        coin_pend_counter #(.W(CNT_W)) u_cnt (
            .clk  (clk),
            .reset(reset),
            .inc  (coin_in[i]),
            .dec  (dec[i]),
            .nz   (nz[i]),
            .drop (drop[i])
        );
    end

    always_comb begin
        state_d   = state_q;
        coin_d    = '0;
        gap_d     = gap_q;
        chg_d     = chg_q;
        to_d      = '0;
        hop_req_d = hop_req_q;
        fault_d   = fault_q;
        rej_d     = |drop;
        case (state_q)
            IDLE: begin
                coin_d  = sel;
                state_d = |nz ? ISSUE : IDLE;
            end
            ISSUE: begin
                gap_d   = GW'(GAP);
                state_d = GAP_WAIT;
            end
            GAP_WAIT: begin
                gap_d = gap_q - GW'(1);
                if (d) begin
                    chg_d     = r;
                    hop_req_d = |r;
                    state_d   = |r ? CHANGE : IDLE;
                end else if (gap_q <= GW'(1)) begin
                    state_d = IDLE;
                end
            end
            CHANGE: begin
                if (hop_ack) begin
                    chg_d = chg_q - CHG_W'(1);
                    if (chg_q == CHG_W'(1)) begin
                        hop_req_d = 1'b0;
                        state_d   = IDLE;
                    end
                end else if (to_q == TW'(HOP_TIMEOUT - 1)) begin
                    fault_d   = 1'b1;
                    chg_d     = '0;
                    hop_req_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            coin_q    <= '0;
            gap_q     <= '0;
            chg_q     <= '0;
            to_q      <= '0;
            hop_req_q <= 1'b0;
            fault_q   <= 1'b0;
            rej_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            coin_q    <= coin_d;
            gap_q     <= gap_d;
            chg_q     <= chg_d;
            to_q      <= to_d;
            hop_req_q <= hop_req_d;
            fault_q   <= fault_d;
            rej_q     <= rej_d;
        end
    end

    assign one         = coin_q[DEN_ONE];
    assign two         = coin_q[DEN_TWO];
    assign five        = coin_q[DEN_FIVE];
    assign hop_req     = hop_req_q;
    assign hop_fault   = fault_q;
    assign coin_reject = rej_q;
    assign busy        = (state_q != IDLE) | (|nz);
endmodule

// File: tb/tb_vend_coin_sequencer.sv
// tb_vend_coin_sequencer: directed steps with a coin-pulse scoreboard checked by a negedge monitor.
module tb_vend_coin_sequencer;
    logic clk = 1'b0, reset = 1'b0;
    logic coin_one = 0, coin_two = 0, coin_five = 0, d = 0, hop_ack = 0;
    logic [2:0] r = '0;
    logic one, two, five, hop_req, coin_reject, busy, hop_fault;
    int total = 0, bad = 0;
    int exp_q[$];
    int n_pulse[3] = '{0, 0, 0};
    int rej_seen = 0, hs = 0;

    vend_coin_sequencer dut (
        .clk(clk), .reset(reset),
        .coin_one(coin_one), .coin_two(coin_two), .coin_five(coin_five),
        .one(one), .two(two), .five(five),
        .d(d), .r(r),
        .hop_req(hop_req), .hop_ack(hop_ack),
        .coin_reject(coin_reject), .busy(busy), .hop_fault(hop_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 60) begin
            tick();
            n++;
        end
        chk(tag, int'(busy), 0);
    endtask

    // pulses coins at c0, raises d with rv during GAP_WAIT (c3); returns in c4
    task automatic start_txn(input logic [2:0] coins, input logic [2:0] rv);
        {coin_five, coin_two, coin_one} = coins;
        for (int i = 0; i < 3; i++) if (coins[i]) exp_q.push_back(i);
        tick();
        {coin_five, coin_two, coin_one} = '0;
        tick();
        tick();
        d = 1'b1;
        r = rv;
        tick();
        d = 1'b0;
        r = '0;
    endtask

    always @(negedge clk) begin
        logic [2:0] p;
        p = {five, two, one};
        if (|p) begin
            chk("onehot", $countones(p), 1);
            for (int i = 0; i < 3; i++) if (p[i]) n_pulse[i]++;
            if (exp_q.size() == 0) chk("unexpected_pulse", int'(p), 0);
            else chk("sb_den", int'(p), 1 << exp_q.pop_front());
        end
        if (coin_reject === 1'b1) rej_seen++;
        if (hop_req === 1'b1 && hop_ack === 1'b1) hs++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0, p1;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_outs", int'({one, two, five, hop_req, coin_reject, hop_fault}), 0);
        #21 reset = 1'b1;
        tick();

        // single coin, no dispense
        coin_two = 1'b1;
        exp_q.push_back(1);
        tick();
        coin_two = 1'b0;
        chk("t1_c1_two", int'(two), 0);
        chk("t1_c1_busy", int'(busy), 1);
        tick();
        chk("t1_c2_two", int'(two), 1);
        tick();
        chk("t1_c3_two", int'(two), 0);
        tick();
        chk("t1_c4_busy", int'(busy), 1);
        tick();
        chk("t1_c5_busy", int'(busy), 0);
        chk("t1_rej", rej_seen, 0);

        // simultaneous one+five
        tick();
        {coin_five, coin_one} = 2'b11;
        exp_q.push_back(0);
        exp_q.push_back(2);
        tick();
        {coin_five, coin_one} = 2'b00;
        tick();
        chk("t2_c2_one", int'(one), 1);
        for (int c = 3; c < 6; c++) begin
            tick();
            chk("t2_gap_five", int'(five), 0);
        end
        tick();
        chk("t2_c6_five", int'(five), 1);
        tick(); tick(); tick();
        chk("t2_c9_busy", int'(busy), 0);

        // dispense r=3, ack every other cycle, coin sensed during CHANGE
        tick();
        hs0 = hs;
        start_txn(3'b001, 3'd3);
        for (int c = 4; c <= 10; c++) begin
            hop_ack = (c % 2 == 1);
            coin_two = (c == 5);
            if (c == 5) exp_q.push_back(1);
            chk("t3_hop_req", int'(hop_req), int'(c <= 9));
            chk("t3_two_held", int'(two), 0);
            tick();
        end
        hop_ack = 1'b0;
        coin_two = 1'b0;
        chk("t3_c11_two", int'(two), 1);
        chk("t3_handshakes", hs - hs0, 3);
        wait_idle("t3_idle");

        // saturation during CHANGE
        p1 = n_pulse[0];
        start_txn(3'b001, 3'd2);
        for (int i = 0; i < 4; i++) begin
            coin_one = 1'b1;
            if (i < 3) exp_q.push_back(0);
            tick();
            chk("t4_reject", int'(coin_reject), int'(i == 3));
        end
        coin_one = 1'b0;
        tick();
        chk("t4_reject_once", int'(coin_reject), 0);
        hop_ack = 1'b1;
        tick(); tick();
        hop_ack = 1'b0;
        chk("t4_hop_drop", int'(hop_req), 0);
        wait_idle("t4_idle");
        chk("t4_one_count", n_pulse[0] - p1, 4);
        chk("t4_rej_total", rej_seen, 1);

        // hopper timeout
        start_txn(3'b010, 3'd2);
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("t5_no_fault_yet", int'(hop_fault), 0);
        end
        chk("t5_req_pending", int'(hop_req), 1);
        tick();
        chk("t5_fault", int'(hop_fault), 1);
        chk("t5_req_off", int'(hop_req), 0);
        chk("t5_idle", int'(busy), 0);
        coin_one = 1'b1;
        exp_q.push_back(0);
        tick();
        coin_one = 1'b0;
        wait_idle("t5_idle2");
        chk("t5_fault_sticky", int'(hop_fault), 1);

        // asynchronous reset mid-CHANGE
        start_txn(3'b100, 3'd3);
        coin_two = 1'b1;
        tick();
        coin_two = 1'b0;
        tick();
        chk("t6_in_change", int'(hop_req), 1);
        #3 reset = 1'b0;
        #1;
        chk("t6_outs", int'({one, two, five, hop_req, coin_reject, hop_fault}), 0);
        chk("t6_busy", int'(busy), 0);
        tick(); tick();
        #3 reset = 1'b1;
        p1 = n_pulse[0] + n_pulse[1] + n_pulse[2];
        for (int i = 0; i < 20; i++) tick();
        chk("t6_no_pulses", n_pulse[0] + n_pulse[1] + n_pulse[2] - p1, 0);
        chk("t6_hop_req", int'(hop_req), 0);
        chk("t6_busy_after", int'(busy), 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
